// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared types and widths for the run/step control block.
// Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    // Width of the switch data path to the CPU.
    localparam int IN_W = 5;
    // Width of the CPU program counter.
    localparam int PC_W = 32;

    // Controller states; the codes are shown directly on the check LEDs.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_WAIT_IN = 2'b10,
        ST_HALT    = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/run_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : N-stage synchronizer followed by a rising-edge detector that
//               emits one single-cycle pulse per button press. A button that
//               is already held when reset is released produces no pulse; it
//               must be seen low first.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge
    import run_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Shift the button through the synchronizer; r_fill marks when the reset
    // zeros have been flushed so the output reflects a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync[0] <= btn;
            r_fill[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
                r_fill[i] <= r_fill[i-1];
            end
            r_prev <= w_level;
            if (r_fill[SYNC_STAGES-1] && !w_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign pulse = w_level & ~r_prev & r_armed;

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run/step/input-handshake controller generating the CPU clock
//               enable. Optional breakpoint support is compiled in with the
//               macro RUN_CTRL_BREAKPOINT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             valid,
    input  logic [IN_W-1:0]  in_sw,
    input  logic             cpu_in_req,
    input  logic             cpu_halt,
    input  logic [PC_W-1:0]  cpu_pc,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_en,
    output logic [IN_W-1:0]  in_data,
    output logic             in_ack,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_run_sync;
    logic                   w_run_s;
    logic                   w_step_p;
    logic                   w_valid_p;
    logic                   r_ack_pend;
    logic                   w_load;
    logic [IN_W-1:0]        r_in_data;
    logic [CNT_W-1:0]       r_cycle_cnt;
    logic                   w_cpu_en;
    logic                   w_in_ack;
    logic                   w_bp_match;
    logic                   w_bp_hit;
    logic                   w_hold;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (step),
        .pulse (w_step_p)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_valid_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (valid),
        .pulse (w_valid_p)
    );

    // Run is a level switch: synchronize only, no edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_sync <= '0;
        end else begin
            r_run_sync[0] <= run;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_run_sync[i] <= r_run_sync[i-1];
            end
        end
    end

    assign w_run_s = r_run_sync[SYNC_STAGES-1];

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic r_hold;

    assign w_bp_match = (cpu_pc == bp_addr);
    assign w_hold     = r_hold;

    // Breakpoint hold: set on a hit, released once the run switch is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 1'b0;
        end else if (w_bp_hit) begin
            r_hold <= 1'b1;
        end else if (!w_run_s) begin
            r_hold <= 1'b0;
        end
    end
`else
    logic w_unused_bp;

    assign w_unused_bp = ^{cpu_pc, bp_addr, w_bp_hit};
    assign w_bp_match  = 1'b0;
    assign w_hold      = 1'b0;
`endif

    // Next state and enable, evaluated in priority order: halt, input
    // request, breakpoint, then run/step. The ack cycle in WAIT_IN ignores
    // cpu_in_req because the CPU consumes in_data in exactly that cycle.
    always_comb begin
        w_next   = r_state;
        w_cpu_en = 1'b0;
        w_in_ack = 1'b0;
        w_bp_hit = 1'b0;
        if (r_state == ST_HALT) begin
            w_next = ST_HALT;
        end else if (cpu_halt) begin
            w_next = ST_HALT;
        end else if (r_state == ST_WAIT_IN) begin
            if (r_ack_pend) begin
                w_cpu_en = 1'b1;
                w_in_ack = 1'b1;
                w_next   = w_run_s ? ST_RUN : ST_IDLE;
            end
        end else if (cpu_in_req) begin
            w_next = ST_WAIT_IN;
        end else if (r_state == ST_RUN) begin
            if (w_bp_match) begin
                w_bp_hit = 1'b1;
                w_next   = ST_IDLE;
            end else if (w_run_s) begin
                w_cpu_en = 1'b1;
            end else begin
                w_next = ST_IDLE;
            end
        end else begin
            w_cpu_en = w_step_p;
            if (w_run_s && !w_hold) begin
                w_next = ST_RUN;
            end
        end
    end

    // A valid press only counts while waiting for input and no ack is queued.
    assign w_load = (r_state == ST_WAIT_IN) && !r_ack_pend && w_valid_p && !cpu_halt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Input latch and the one-cycle-deferred acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_data  <= '0;
            r_ack_pend <= 1'b0;
        end else begin
            r_ack_pend <= w_load;
            if (w_load) begin
                r_in_data <= in_sw;
            end
        end
    end

    // Saturating count of enabled CPU cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
        end else if (w_cpu_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign cpu_en    = w_cpu_en;
    assign in_ack    = w_in_ack;
    assign in_data   = r_in_data;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_run_ctrl
// Description : Self-checking bench for run_ctrl with a behavioural model.
//               Breakpoint scenario is built when RUN_CTRL_BREAKPOINT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             valid = 1'b0;
    logic [4:0]       in_sw = '0;
    logic             cpu_in_req = 1'b0;
    logic             cpu_halt = 1'b0;
    logic [31:0]      cpu_pc = '0;
    logic [31:0]      bp_addr = 32'hFFFF_FFF0;
    logic             cpu_en;
    logic [4:0]       in_data;
    logic             in_ack;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;

    int tests = 0;
    int fails = 0;
    int ack_seen = 0;
    int en_seen = 0;
    int saved = 0;

    // Behavioural model. Mode values are the spec's state codes.
    // Synchronizer queues hold raw samples; -1 marks reset fill (no sample yet).
    int m_mode, m_in_data, m_cnt;
    bit m_ack_pend, m_hold;
    int q_run[$], q_step[$], q_valid[$];
    int p_step, p_valid;
    bit e_en, e_ack, e_load, e_bp, e_run_s;
    int e_next;

    run_ctrl #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .valid      (valid),
        .in_sw      (in_sw),
        .cpu_in_req (cpu_in_req),
        .cpu_halt   (cpu_halt),
        .cpu_pc     (cpu_pc),
        .bp_addr    (bp_addr),
        .cpu_en     (cpu_en),
        .in_data    (in_data),
        .in_ack     (in_ack),
        .state      (state),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_in_data = 0; m_cnt = 0; m_ack_pend = 0; m_hold = 0;
        q_run.delete(); q_step.delete(); q_valid.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            q_run.push_back(-1); q_step.push_back(-1); q_valid.push_back(-1);
        end
        p_step = -1; p_valid = -1;
    endtask

    // Expected behaviour of the current cycle from the spec's priority rules.
    task automatic model_eval();
        bit step_p, valid_p;
        e_run_s = (q_run[0] == 1);
        step_p  = (q_step[0] == 1) && (p_step == 0);
        valid_p = (q_valid[0] == 1) && (p_valid == 0);
        e_en = 0; e_ack = 0; e_load = 0; e_bp = 0; e_next = m_mode;
        if (m_mode == 3) begin
            e_next = 3;
        end else if (cpu_halt) begin
            e_next = 3;
        end else if (m_mode == 2) begin
            if (m_ack_pend) begin
                e_en = 1; e_ack = 1; e_next = e_run_s ? 1 : 0;
            end else if (valid_p) begin
                e_load = 1;
            end
        end else if (cpu_in_req) begin
            e_next = 2;
`ifdef RUN_CTRL_BREAKPOINT_EN
        end else if (m_mode == 1 && cpu_pc == bp_addr) begin
            e_bp = 1; e_next = 0;
`endif
        end else if (m_mode == 1) begin
            if (e_run_s) e_en = 1;
            else e_next = 0;
        end else begin
            e_en = step_p;
            if (e_run_s && !m_hold) e_next = 1;
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (e_en && m_cnt < CNT_MAX) m_cnt++;
        if (e_load) m_in_data = int'(in_sw);
        m_ack_pend = e_load;
        if (e_bp) m_hold = 1;
        else if (!e_run_s) m_hold = 0;
        m_mode = e_next;
        p_step = q_step[0]; p_valid = q_valid[0];
        q_run.push_back(int'(run));     void'(q_run.pop_front());
        q_step.push_back(int'(step));   void'(q_step.pop_front());
        q_valid.push_back(int'(valid)); void'(q_valid.pop_front());
    endtask

    // One clock: compare on the falling edge, advance the model on the rising
    // edge, then let the modelled CPU react (PC advance, request cleared by ack).
    task automatic tick();
        bit en_q, ack_q;
        @(negedge clk);
        model_eval();
        chk("cpu_en", cpu_en, e_en);
        chk("in_ack", in_ack, e_ack);
        chk("state", state, m_mode);
        chk("in_data", in_data, m_in_data);
        chk("cycle_cnt", cycle_cnt, m_cnt);
        if (in_ack === 1'b1) ack_seen++;
        if (cpu_en === 1'b1) en_seen++;
        en_q = e_en; ack_q = e_ack;
        @(posedge clk);
        model_commit();
        #1;
        if (en_q) cpu_pc = cpu_pc + 1;
        if (ack_q) cpu_in_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_state", state, 0);
        chk("rst_en", cpu_en, 0);
        chk("rst_ack", in_ack, 0);
        chk("rst_data", in_data, 0);
        chk("rst_cnt", cycle_cnt, 0);
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input bit is_step, input int hi, input int lo);
        if (is_step) step = 1'b1; else valid = 1'b1;
        repeat (hi) tick();
        if (is_step) step = 1'b0; else valid = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        rst_n = 1'b1;
        #2;
        do_reset(3);
        repeat (4) tick();

        // Single step from IDLE.
        press(1, 4, 6);
        chk("step_cnt", cycle_cnt, 1);
        chk("step_state", state, 0);

        // Free run for 300 cycles; counter saturates.
        run = 1'b1; en_seen = 0;
        repeat (300) tick();
        chk("run_en_cycles", en_seen, 300 - (SYNC_STAGES + 1));
        chk("run_state", state, 1);
        chk("cnt_saturated", cycle_cnt, CNT_MAX);
        run = 1'b0;
        repeat (5) tick();
        chk("stop_state", state, 0);
        chk("stop_en", cpu_en, 0);

        // Input handshake from RUN.
        do_reset(2);
        run = 1'b1;
        repeat (6) tick();
        cpu_in_req = 1'b1;
        repeat (2) tick();
        chk("wait_state", state, 2);
        chk("wait_en", cpu_en, 0);
        in_sw = 5'b00100; ack_seen = 0;
        press(0, 3, 6);
        chk("hs_data", in_data, 4);
        chk("hs_acks", ack_seen, 1);
        chk("hs_state", state, 1);

        // Valid presses with no request are ignored.
        run = 1'b0;
        do_reset(2);
        ack_seen = 0;
        press(0, 3, 3);
        press(0, 3, 3);
        for (int i = 0; i < 200; i++) begin
            in_sw = 5'($urandom_range(31));
            tick();
        end
        chk("ign_data", in_data, 0);
        chk("ign_acks", ack_seen, 0);

        // Reset mid-handshake, valid held through reset release.
        do_reset(2);
        cpu_in_req = 1'b1; in_sw = 5'h1B;
        repeat (3) tick();
        valid = 1'b1;
        for (int i = 0; i < 10 && !m_ack_pend; i++) tick();
        chk("ack_mid", in_ack, 1);
        do_reset(3);
        ack_seen = 0;
        repeat (10) tick();
        chk("post_rst_acks", ack_seen, 0);
        chk("post_rst_state", state, 2);
        valid = 1'b0;
        repeat (3) tick();
        press(0, 3, 6);
        chk("re_ack", ack_seen, 1);
        chk("re_data", in_data, 5'h1B);

        // Step held through reset release must not execute.
        step = 1'b1;
        do_reset(2);
        repeat (8) tick();
        chk("held_step_cnt", cycle_cnt, 0);
        step = 1'b0;
        repeat (3) tick();

        // Halt is absorbing.
        run = 1'b1;
        repeat (6) tick();
        cpu_halt = 1'b1;
        repeat (2) tick();
        chk("halt_state", state, 3);
        chk("halt_en", cpu_en, 0);
        saved = m_cnt;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) run = ~run;
            if ($urandom_range(2) == 0) step = ~step;
            if ($urandom_range(2) == 0) valid = ~valid;
            cpu_halt = 1'($urandom_range(1));
            tick();
        end
        chk("halt_cnt_frozen", cycle_cnt, saved);
        chk("halt_state_end", state, 3);
        cpu_halt = 1'b0; run = 1'b0; step = 1'b0; valid = 1'b0;
        do_reset(2);
        chk("halt_rst_state", state, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) run = ~run;
            if ($urandom_range(5) == 0) step = ~step;
            if ($urandom_range(5) == 0) valid = ~valid;
            if (!cpu_in_req && $urandom_range(49) == 0) cpu_in_req = 1'b1;
            in_sw = 5'($urandom_range(31));
            tick();
        end

`ifdef RUN_CTRL_BREAKPOINT_EN
        // Breakpoint stop, single step under hold, then resume.
        run = 1'b0; step = 1'b0; valid = 1'b0; cpu_in_req = 1'b0;
        do_reset(2);
        cpu_pc = 32'h0; bp_addr = 32'h10;
        run = 1'b1;
        repeat (40) tick();
        chk("bp_state", state, 0);
        chk("bp_en", cpu_en, 0);
        chk("bp_cnt", cycle_cnt, 16);
        press(1, 4, 6);
        chk("bp_step_cnt", cycle_cnt, 17);
        chk("bp_step_state", state, 0);
        run = 1'b0;
        repeat (5) tick();
        run = 1'b1;
        repeat (8) tick();
        chk("bp_resume_state", state, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each button input.
REQ-002 Parameter CNT_W, default 16, width of the enabled-cycle counter.
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 run  in  1  run switch: level high requests free-running execution.
REQ-006 step  in  1  step button: each rising edge requests one CPU cycle.
REQ-007 valid  in  1  input-valid button: rising edge commits in_sw to the CPU.
REQ-008 in_sw  in  5  switch data offered to the CPU.
REQ-009 cpu_in_req  in  1  CPU is stalled on an input read.
REQ-010 cpu_halt  in  1  CPU reached its halt instruction.
REQ-011 cpu_pc  in  32  current CPU PC, used by the breakpoint feature only.
REQ-012 bp_addr  in  32  breakpoint address, used by the breakpoint feature only.
REQ-013 cpu_en  out  1  CPU clock enable, combinational from state and synchronized inputs.
REQ-014 in_data  out  5  latched input value.
REQ-015 in_ack  out  1  one-cycle pulse, in_data valid for the CPU.
REQ-016 state  out  2  current state code, drives the check LEDs.
REQ-017 cycle_cnt  out  CNT_W  count of cycles with cpu_en=1.

Function
REQ-018 step and valid SHALL pass through SYNC_STAGES flops and then rising-edge detection; each press yields exactly one 1-cycle pulse (step_p, valid_p); run SHALL be synchronized, not edge-detected.
REQ-019 States: IDLE=00, RUN=01, WAIT_IN=10, HALT=11; the state output SHALL equal the current code.
REQ-020 Event priority, highest first: cpu_halt, cpu_in_req, breakpoint, run/step.
REQ-021 IDLE: cpu_en=0, except cpu_en=1 for the step_p cycle when cpu_in_req=0 and cpu_halt=0; synchronized run=1 -> RUN next cycle.
REQ-022 RUN: cpu_en=1 while run=1, cpu_in_req=0, cpu_halt=0; run=0 -> IDLE with cpu_en=0 in that cycle; step_p ignored.
REQ-023 Any state except HALT with cpu_in_req=1 -> WAIT_IN, cpu_en=0 in that cycle.
REQ-024 WAIT_IN: cpu_en=0; on valid_p, in_data<=in_sw; the following cycle in_ack=1 and cpu_en=1 for exactly one cycle; state then becomes RUN if run=1, else IDLE.
REQ-025 valid_p outside WAIT_IN SHALL be ignored: in_data unchanged, no in_ack.
REQ-026 cpu_halt=1 in any state -> HALT; HALT is absorbing with cpu_en=0 until reset; step, run and valid are ignored.
REQ-027 cycle_cnt SHALL increment by 1 on every cycle with cpu_en=1 and saturate at all-ones.
REQ-028 run falling while in WAIT_IN: remain in WAIT_IN and return to IDLE after the ack cycle.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, cpu_en=0, in_data=0, in_ack=0, cycle_cnt=0, synchronizers and edge detectors=0, and the breakpoint hold=0.
REQ-030 Reset asserted mid-handshake SHALL discard any pending ack; no in_ack after reset release without a new valid_p in WAIT_IN.
REQ-031 A button held through reset release SHALL NOT produce an edge pulse.

Configuration
REQ-032 Macro RUN_CTRL_BREAKPOINT_EN compiles the breakpoint feature in.
REQ-033 With RUN_CTRL_BREAKPOINT_EN: in RUN, cpu_pc==bp_addr -> IDLE with cpu_en=0 in that cycle and the breakpoint hold set.
REQ-034 With RUN_CTRL_BREAKPOINT_EN: while the hold is set, IDLE->RUN is blocked; the hold clears when synchronized run=0; step_p still executes one cycle.
REQ-035 Without the macro: cpu_pc and bp_addr remain ports but are unused, there is no hold logic, and all other behaviour is identical.

Structure
REQ-036 Package run_ctrl_pkg SHALL hold the state enum with the codes above plus IN_W=5 and PC_W=32.
REQ-037 Sub-module btn_edge (N-stage synchronizer plus rising-edge pulse) SHALL be instantiated for step and valid.

Verification
REQ-038 Reset, run=0, one step press -> exactly one cpu_en cycle, cycle_cnt=1, state=00.
REQ-039 run=1 for 300 cycles -> cpu_en continuous after sync latency, state=01; run=0 -> cpu_en=0, state=00.
REQ-040 RUN, cpu_in_req=1 -> state=10, cpu_en=0; in_sw=5'b00100, valid press -> in_data=4, one-cycle in_ack with cpu_en=1, then state=01.
REQ-041 Two valid presses in IDLE, then 200 in_sw toggles with no request -> in_data stays 0, in_ack never asserted.
REQ-042 cpu_halt=1 during RUN -> state=11, cpu_en=0, cycle_cnt frozen despite step and run activity; rst_n low -> state=00.
REQ-043 With RUN_CTRL_BREAKPOINT_EN, bp_addr=0x10, PC reaches 0x10 -> state=00 with run still 1; step executes one cycle; run 0->1 resumes RUN.
